mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, line address width on every port.
REQ-002 Parameter DATA_W, default 128, cache line width on every data port.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 proc_reset  input  1  synchronous, active-high reset.
REQ-005 I_read  input  1  I-cache line-fill request, level, held until served.
REQ-006 I_addr  input  ADDR_W  I-cache line address.
REQ-007 I_rdata  output  DATA_W  fill data returned to the I-cache.
REQ-008 I_ready  output  1  one-cycle pulse: I_rdata valid, I request complete.
REQ-009 D_read  input  1  D-cache line-fill request, level.
REQ-010 D_write  input  1  D-cache write-back request, level; never asserted together with D_read.
REQ-011 D_addr  input  ADDR_W  D-cache line address.
REQ-012 D_wdata  input  DATA_W  D-cache write-back line.
REQ-013 D_rdata  output  DATA_W  fill data returned to the D-cache.
REQ-014 D_ready  output  1  one-cycle pulse: D request complete.
REQ-015 mem_read  output  1  memory read strobe.
REQ-016 mem_write  output  1  memory write strobe.
REQ-017 mem_addr  output  ADDR_W  memory line address.
REQ-018 mem_wdata  output  DATA_W  memory write line.
REQ-019 mem_rdata  input  DATA_W  memory read line, valid when mem_ready is 1.
REQ-020 mem_ready  input  1  memory completion, one-cycle pulse.

Function
REQ-021 FSM states: IDLE, BUSY_I, BUSY_D, DONE.
REQ-022 IDLE: unmasked D request (D_read|D_write) -> BUSY_D; else unmasked I_read -> BUSY_I; else stay.
REQ-023 On entering BUSY_x, the block latches the requester's address, wdata and op (read/write) into internal registers; mem_* outputs are driven only from these registers.
REQ-024 BUSY_x: mem_read or mem_write equals the latched op and stays asserted until the cycle mem_ready=1; it is 0 in every other state.
REQ-025 The block registers mem_ready and mem_rdata; in the cycle after mem_ready=1, x_ready=1 for exactly one cycle, x_rdata=registered mem_rdata, and the state is DONE.
REQ-026 x_rdata holds its value until the next completion on that port; x_ready on the other port stays 0.
REQ-027 DONE lasts exactly one cycle, then IDLE; during DONE and the following IDLE cycle, the just-served requester is masked, because a cache drops its request one cycle after seeing ready.
REQ-028 Minimum latency: request high at edge N -> mem strobe high from cycle N+1 -> x_ready in the cycle after mem_ready.
REQ-029 Simultaneous I and D requests in IDLE: arbitration policy per REQ-033/034; the loser keeps its request and is served after DONE with no extra idle cycle beyond the mask.
REQ-030 Request inputs changing during BUSY_x or DONE do not affect mem_* outputs.

Reset
REQ-031 proc_reset=1 at a clock edge -> state IDLE, mask cleared, all outputs 0 (mem_read, mem_write, mem_addr, mem_wdata, I_ready, D_ready, I_rdata, D_rdata) from the next cycle.
REQ-032 Reset mid-transaction aborts it: no x_ready pulse is produced, and a late mem_ready arriving in IDLE is ignored.

Configuration
REQ-033 Macro ARB_RR_EN defined: round-robin. A 1-bit last-grant register (reset to I) gives the simultaneous-request tie to the port not granted last.
REQ-034 ARB_RR_EN undefined: fixed priority, D over I, on every tie; no last-grant register.

Verification
REQ-035 Lone I_read, I_addr=0x0000123, memory ready 3 cycles later with rdata=0xA5..A5 -> mem_read=1, mem_addr=0x0000123 for 3 cycles; I_ready pulse one cycle later with I_rdata=0xA5..A5.
REQ-036 D_write, D_addr=0x00000F0, D_wdata=0x1111_2222_3333_4444 -> mem_write=1 with matching addr/wdata until mem_ready; D_ready pulse; mem_read never asserted.
REQ-037 I_read and D_read raised in the same cycle, both held until their ready -> D served first in both configurations; with ARB_RR_EN, a second simultaneous pair is served I first.
REQ-038 Requester holds its request one cycle after x_ready -> exactly one memory transaction per request; no duplicate strobe.
REQ-039 proc_reset asserted while in BUSY_D, mem_ready pulsed 2 cycles later -> all outputs 0, D_ready never pulses, FSM is IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto one memory port.
// Define ARB_RR_EN for round-robin tie-break; default build is fixed D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              I_read,
  input  logic [ADDR_W-1:0] I_addr,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  state_e              state_q, state_d;
  logic                served_d_q;
  logic                mask_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                d_req, i_req, grant_d, grant_i;
`ifdef ARB_RR_EN
  logic                last_d_q;
`endif

  // The port served last stays masked for the IDLE cycle after DONE, while its cache drops the request.
  always_comb begin
    d_req = (D_read | D_write) & ~(mask_q & served_d_q);
    i_req = I_read & ~(mask_q & ~served_d_q);
`ifdef ARB_RR_EN
    grant_d = d_req & ~(i_req & last_d_q);
`else
    grant_d = d_req;
`endif
    grant_i = i_req & ~grant_d;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: if (mem_ready) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      served_d_q <= 1'b0;
      mask_q     <= 1'b0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_RR_EN
      last_d_q   <= 1'b0;
`endif
    end else begin
      mask_q <= (state_q == DONE);
      if (state_q == IDLE && (grant_d || grant_i)) begin
        served_d_q <= grant_d;
        addr_q     <= grant_d ? D_addr : I_addr;
        wdata_q    <= grant_d ? D_wdata : '0;
        op_wr_q    <= grant_d & D_write;
`ifdef ARB_RR_EN
        // Only a genuine tie moves the round-robin pointer.
        if (d_req && i_req) last_d_q <= grant_d;
`endif
      end
      if (mem_ready && state_q == BUSY_I)             i_rdata_q <= mem_rdata;
      if (mem_ready && state_q == BUSY_D && !op_wr_q) d_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    logic busy;
    busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
    mem_read  = busy & ~op_wr_q;
    mem_write = busy & op_wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    I_ready   = (state_q == DONE) & ~served_d_q;
    D_ready   = (state_q == DONE) & served_d_q;
    I_rdata   = i_rdata_q;
    D_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: memory model checks expected transactions, monitor checks completions.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk;
  logic          proc_reset;
  logic          I_read, D_read, D_write;
  logic [AW-1:0] I_addr, D_addr, mem_addr;
  logic [DW-1:0] I_rdata, D_rdata, D_wdata, mem_wdata, mem_rdata;
  logic          I_ready, D_ready, mem_read, mem_write, mem_ready;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .I_read(I_read), .I_addr(I_addr), .I_rdata(I_rdata), .I_ready(I_ready),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rdata(D_rdata), .D_ready(D_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata;} mem_t;
  typedef struct {bit d; bit chk_data; logic [DW-1:0] data;} rsp_t;

  mem_t exp_mem[$];
  rsp_t exp_rsp[$];
  mem_t cur;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rd_cycles = 0, wr_cycles = 0, txn_cnt = 0, run = 0;
  int   mem_lat = 3;
  bit   mem_auto = 1'b1;
  bit   force_pulse = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit d, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(d ? D_ready : I_ready) && k < 40);
    chk(d ? "wait_D_ready" : "wait_I_ready", d ? D_ready : I_ready, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_I_ready"}, I_ready, 0);
    chk({tag, "_D_ready"}, D_ready, 0);
    chk({tag, "_I_rdata"}, I_rdata, 0);
    chk({tag, "_D_rdata"}, D_rdata, 0);
  endtask

  // Memory model: pops the expected transaction on the first strobe cycle, answers after mem_lat strobe cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (force_pulse) begin
        mem_ready = 1'b1;
        force_pulse = 1'b0;
      end else if (mem_read || mem_write) begin
        run++;
        if (mem_read)  rd_cycles++;
        if (mem_write) wr_cycles++;
        if (run == 1) begin
          txn_cnt++;
          chk("mem_txn_expected", exp_mem.size() != 0, 1);
          if (exp_mem.size() != 0) begin
            cur = exp_mem.pop_front();
            chk("mem_op_write", mem_write, cur.wr);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end
        if (mem_auto && run == mem_lat) begin
          chk("mem_addr_held", mem_addr, cur.addr);
          chk("mem_wdata_held", mem_wdata, cur.wdata);
          mem_ready = 1'b1;
          mem_rdata = cur.rdata;
        end
      end else begin
        run = 0;
      end
    end
  end

  // Completion monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (I_ready || D_ready) begin
        chk("rsp_expected", exp_rsp.size() != 0, 1);
        chk("rsp_one_port", I_ready & D_ready, 0);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          chk("rsp_port_D", D_ready, e.d);
          if (e.chk_data) chk(e.d ? "D_rdata" : "I_rdata", e.d ? D_rdata : I_rdata, e.data);
        end
      end
    end
  end

  task automatic tie(input bit d_first, input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                     input logic [DW-1:0] di, input logic [DW-1:0] dd);
    int k, t0;
    t0 = txn_cnt;
    if (d_first) begin
      exp_mem.push_back('{1'b0, ad, '0, dd}); exp_rsp.push_back('{1'b1, 1'b1, dd});
      exp_mem.push_back('{1'b0, ai, '0, di}); exp_rsp.push_back('{1'b0, 1'b1, di});
    end else begin
      exp_mem.push_back('{1'b0, ai, '0, di}); exp_rsp.push_back('{1'b0, 1'b1, di});
      exp_mem.push_back('{1'b0, ad, '0, dd}); exp_rsp.push_back('{1'b1, 1'b1, dd});
    end
    step();
    I_read = 1'b1; I_addr = ai;
    D_read = 1'b1; D_addr = ad;
    wait_ready(d_first, k);
    chk("tie_first_latency", k, 5);
    step(); step();
    if (d_first) D_read = 1'b0; else I_read = 1'b0;
    wait_ready(!d_first, k);
    chk("tie_second_gap", k, 4);
    step(); step();
    if (d_first) I_read = 1'b0; else D_read = 1'b0;
    repeat (3) step();
    chk("tie_txn_count", txn_cnt - t0, 2);
  endtask

  initial begin
    int k, t0, rd0, wr0;
    logic [DW-1:0] w;
    proc_reset = 1'b1;
    I_read = 1'b0; I_addr = '0;
    D_read = 1'b0; D_write = 1'b0; D_addr = '0; D_wdata = '0;
    step(); step();
    proc_reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Lone I fill.
    exp_mem.push_back('{1'b0, 28'h0000123, '0, {16{8'hA5}}});
    exp_rsp.push_back('{1'b0, 1'b1, {16{8'hA5}}});
    rd0 = rd_cycles; t0 = txn_cnt;
    step();
    I_read = 1'b1; I_addr = 28'h0000123;
    wait_ready(1'b0, k);
    chk("i_latency", k, 5);
    step(); step();
    I_read = 1'b0;
    repeat (3) step();
    chk("i_read_cycles", rd_cycles - rd0, 3);
    chk("i_single_txn", txn_cnt - t0, 1);

    // D write-back; inputs disturbed mid-transaction must not reach mem_*.
    w = 128'h1111_2222_3333_4444;
    exp_mem.push_back('{1'b1, 28'h00000F0, w, '0});
    exp_rsp.push_back('{1'b1, 1'b0, '0});
    rd0 = rd_cycles; wr0 = wr_cycles; t0 = txn_cnt;
    step();
    D_write = 1'b1; D_addr = 28'h00000F0; D_wdata = w;
    step(); step();
    D_addr = 28'h0ABCDEF; D_wdata = '1;
    wait_ready(1'b1, k);
    chk("d_write_latency_rest", k, 3);
    step(); step();
    D_write = 1'b0; D_wdata = '0; D_addr = '0;
    repeat (3) step();
    chk("d_write_cycles", wr_cycles - wr0, 3);
    chk("d_write_no_read", rd_cycles - rd0, 0);
    chk("d_write_single_txn", txn_cnt - t0, 1);

    // Simultaneous requests: D first always; second pair alternates under round-robin.
    tie(1'b1, 28'h0000200, 28'h0000300, {4{32'h1111_AAAA}}, {4{32'hDDDD_0001}});
`ifdef ARB_RR_EN
    tie(1'b0, 28'h0000400, 28'h0000500, {4{32'h2222_BBBB}}, {4{32'hDDDD_0002}});
`else
    tie(1'b1, 28'h0000400, 28'h0000500, {4{32'h2222_BBBB}}, {4{32'hDDDD_0002}});
`endif

    // Reset during BUSY_D, then a late mem_ready while IDLE.
    mem_auto = 1'b0;
    exp_mem.push_back('{1'b0, 28'h0000555, '0, '0});
    step();
    D_read = 1'b1; D_addr = 28'h0000555;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_read && k < 10);
    chk("abort_busy_reached", mem_read, 1);
    step();
    proc_reset = 1'b1; D_read = 1'b0;
    step();
    proc_reset = 1'b0;
    @(negedge clk);
    check_zero("abort");
    step();
    force_pulse = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_D_ready", D_ready, 0);
      chk("abort_no_strobe", mem_read | mem_write, 0);
    end
    mem_auto = 1'b1;
    exp_mem.push_back('{1'b0, 28'h0000777, '0, {8{16'h5A5A}}});
    exp_rsp.push_back('{1'b0, 1'b1, {8{16'h5A5A}}});
    step();
    I_read = 1'b1; I_addr = 28'h0000777;
    wait_ready(1'b0, k);
    chk("post_abort_latency", k, 5);
    step(); step();
    I_read = 1'b0;
    repeat (3) step();

    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
